pad_gpio_ctrl: RTL and testbench
================================

Name: pad_gpio_ctrl

Overview:
- Core-side controller for a bank of bidirectional pad cells. Drives each cell's IN and active-low OEN, and takes back each cell's OUT.
- Synchronises and debounces pad inputs, detects edges and raises an interrupt.
- Software-visible through a single-cycle register port. Sits between the SoC register bus and the pad ring.

Parameters:
- NumPins, 8, number of pads controlled; 1..32.
- DebounceCycles, 4, consecutive stable cycles before a filtered input changes; >=1.
- SyncStages, 2, input synchroniser depth; >=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- reg_req_i  in  1  register access strobe, single cycle.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  5  byte address, word aligned.
- reg_wdata_i  in  32  write data; bits >= NumPins ignored.
- reg_rdata_o  out  32  read data, valid with reg_rvalid_o.
- reg_rvalid_o  out  1  response strobe, one cycle after reg_req_i (reads and writes).
- reg_error_o  out  1  qualifies reg_rvalid_o; unmapped or misaligned address.
- pad_in_o  out  NumPins  to pad cell IN (value driven when enabled).
- pad_oen_o  out  NumPins  to pad cell OEN; 0 = drive, 1 = hi-Z.
- pad_out_i  in  NumPins  from pad cell OUT (asynchronous).
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (rst_i high at clk_i edge):
  - pad_in_o=0 and pad_oen_o=all 1s (all pads hi-Z).
  - All registers, sync stages, filtered values and counters = 0.
  - reg_rvalid_o=0, reg_error_o=0, reg_rdata_o=0, irq_o=0.
  - Reset mid-debounce discards the pending count.
- Register map (offset, access):
  - 0x00 DOUT rw -> pad_in_o.
  - 0x04 DIR rw; pad_oen_o = ~DIR.
  - 0x08 DIN ro (filtered inputs).
  - 0x0C RISE_EN rw.
  - 0x10 FALL_EN rw.
  - 0x14 STATUS rw1c.
  - 0x18 IRQ_EN rw.
- Unmapped address or reg_addr_i[1:0]!=0:
  - Writes have no effect.
  - Reads return 0.
  - reg_error_o=1 with reg_rvalid_o.
- Register access timing:
  - Writes take effect at the request edge, so pad outputs change the cycle after reg_req_i.
  - Read data reflects register state before any same-cycle update.
  - Unused upper bits read 0.
- Synchroniser: SyncStages flops per pin, no reset dependency on pad state. The last stage is s[i].
- Debounce, per pin, counter width $clog2(DebounceCycles+1):
  - If s[i]==filt[i]: cnt<=0.
  - Otherwise cnt<=cnt+1.
  - When cnt+1==DebounceCycles: filt[i] toggles and cnt<=0.
  - Pad change sampled at edge k appears in filt at edge k+SyncStages-1+DebounceCycles.
  - A glitch shorter than DebounceCycles cycles at s[i] never reaches filt.
- Edge detection: at the edge where filt[i] toggles 0->1 (1->0), STATUS[i] sets if RISE_EN[i] (FALL_EN[i]).
- STATUS clear: write-1 clears. A same-cycle set and clear on the same bit leaves it set (set wins).
- irq_o = |(STATUS & IRQ_EN), combinational from registers. It asserts the cycle after the toggle edge.
- Pads configured as outputs still feed back through pad_out_i; DIN and edge detection operate regardless of DIR.

Decomposition:
- Package pad_gpio_pkg holds:
  - register offset localparams (REG_DOUT..REG_IRQ_EN);
  - reg_addr_t (logic [4:0]);
  - a data-width constant of 32.
- Sub-module pad_gpio_debounce: one pin. It contains the sync chain, debounce counter and filt, and produces rise/fall pulses. It is instantiated NumPins times in a generate loop.
- The top level holds the register file, bus response logic and IRQ reduction.

Test Plan:
- Reset, then read all registers:
  - pad_oen_o=8'hFF, pad_in_o=0, irq_o=0.
  - Each read returns 0 with rvalid one cycle later and error=0.
- Write DIR=8'h0F then DOUT=8'hA5:
  - After the second write edge, pad_oen_o=8'hF0 and pad_in_o=8'hA5.
  - Read DIN after a loopback pad model settles (>=6 cycles) returns 8'hA5.
- Set RISE_EN=8'h01, IRQ_EN=8'h01. Raise pad_out_i[0] at edge k (default parameters):
  - DIN[0]=1 at edge k+5, with STATUS[0]=1 at the same edge.
  - irq_o=1 in the following cycle.
  - Write STATUS=1 drops irq_o the next cycle.
- Pulse pad_out_i[1] high for 3 cycles, with FALL_EN and RISE_EN all 1s:
  - DIN[1] stays 0, STATUS stays 0.
  - A 4-cycle pulse yields both rise and fall, so STATUS[1]=1.
- Write STATUS=1 in the same cycle the rising toggle on pin 0 sets it -> STATUS[0] reads 1.
- Read 0x1C and 0x06 -> rdata=0, error=1. Assert rst_i mid-debounce -> counters cleared, outputs at reset values.

Source files
------------

// File: rtl/pad_gpio_pkg.sv
// Purpose: shared register map, address type and helpers for the pad GPIO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_gpio_pkg;

  localparam int unsigned DataWidth = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_DOUT    = 5'h00;
  localparam reg_addr_t REG_DIR     = 5'h04;
  localparam reg_addr_t REG_DIN     = 5'h08;
  localparam reg_addr_t REG_RISE_EN = 5'h0C;
  localparam reg_addr_t REG_FALL_EN = 5'h10;
  localparam reg_addr_t REG_STATUS  = 5'h14;
  localparam reg_addr_t REG_IRQ_EN  = 5'h18;

  // Word aligned and inside the contiguous block DOUT..IRQ_EN.
  function automatic logic addr_is_mapped(input reg_addr_t addr);
    return (addr[1:0] == 2'b00) && (addr <= REG_IRQ_EN);
  endfunction

endpackage

// File: rtl/pad_gpio_debounce.sv
// Purpose: one pin's input path: synchroniser chain, debounce counter, filtered value, edge pulses.
// Latency: pad change sampled at edge k reaches filt_o at edge k+SyncStages-1+DebounceCycles.
// Backpressure: none; free-running every cycle.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   pad_i        : raw asynchronous pad value
//   filt_o       : debounced level
//   rise_o/fall_o: combinational, high in the cycle whose edge toggles filt_o 0->1 / 1->0
module pad_gpio_debounce #(
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned SyncStages     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  // One bit wider than the counter so cnt+1 never wraps before the compare.
  localparam logic [CntW:0] CntMax = (CntW + 1)'(DebounceCycles);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW:0]         cnt_inc;
  logic                  filt_q, filt_d;
  logic                  s;

  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], pad_i};
    s       = sync_q[SyncStages-1];
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    cnt_d   = '0;
    filt_d  = filt_q;
    // Any cycle where s agrees with filt restarts the count, so a glitch
    // shorter than DebounceCycles never gets through.
    if (s != filt_q) begin
      if (cnt_inc == CntMax) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_inc[CntW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_d & ~filt_q;
  assign fall_o = ~filt_d & filt_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Purpose: core-side controller for a bank of bidirectional pads: register file, bus response, edge IRQ.
// Latency: register response one cycle after reg_req_i; writes visible on pads the cycle after the request.
// Backpressure: none; every request is accepted and answered, bad addresses flagged via reg_error_o.
//
// Ports:
//   clk_i, rst_i                          : clock, synchronous active-high reset
//   reg_req_i/we_i/addr_i/wdata_i         : single-cycle register request
//   reg_rdata_o/rvalid_o/error_o          : registered response
//   pad_in_o, pad_oen_o (active low), pad_out_i : pad cell interface
//   irq_o                                 : level interrupt, |(STATUS & IRQ_EN)
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int unsigned NumPins        = 8,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned SyncStages     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  reg_addr_t            reg_addr_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_rvalid_o,
  output logic                 reg_error_o,
  output logic [NumPins-1:0]   pad_in_o,
  output logic [NumPins-1:0]   pad_oen_o,
  input  logic [NumPins-1:0]   pad_out_i,
  output logic                 irq_o
);

  logic [NumPins-1:0] dout_q, dout_d;
  logic [NumPins-1:0] dir_q, dir_d;
  logic [NumPins-1:0] rise_en_q, rise_en_d;
  logic [NumPins-1:0] fall_en_q, fall_en_d;
  logic [NumPins-1:0] status_q, status_d;
  logic [NumPins-1:0] irq_en_q, irq_en_d;

  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, error_q, error_d;

  logic [NumPins-1:0] filt, rise, fall;
  logic [NumPins-1:0] wdat, status_clr, status_set;
  logic [DataWidth-1:0] rd_word;
  logic               mapped, wr_en;

  // Bits of reg_wdata_i above NumPins are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i;

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    pad_gpio_debounce #(
      .DebounceCycles(DebounceCycles),
      .SyncStages    (SyncStages)
    ) u_deb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pad_i (pad_out_i[i]),
      .filt_o(filt[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  always_comb begin
    mapped = addr_is_mapped(reg_addr_i);
    wr_en  = reg_req_i & reg_we_i & mapped;
    wdat   = reg_wdata_i[NumPins-1:0];

    dout_d     = dout_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_en_d   = irq_en_q;
    status_clr = '0;

    if (wr_en) begin
      case (reg_addr_i)
        REG_DOUT:    dout_d     = wdat;
        REG_DIR:     dir_d      = wdat;
        REG_RISE_EN: rise_en_d  = wdat;
        REG_FALL_EN: fall_en_d  = wdat;
        REG_STATUS:  status_clr = wdat;
        REG_IRQ_EN:  irq_en_d   = wdat;
        default:     ;
      endcase
    end

    // Set is applied after clear so a simultaneous event is never lost.
    status_set = (rise & rise_en_q) | (fall & fall_en_q);
    status_d   = (status_q & ~status_clr) | status_set;

    // Read data comes from pre-update state.
    rd_word = '0;
    case (reg_addr_i)
      REG_DOUT:    rd_word[NumPins-1:0] = dout_q;
      REG_DIR:     rd_word[NumPins-1:0] = dir_q;
      REG_DIN:     rd_word[NumPins-1:0] = filt;
      REG_RISE_EN: rd_word[NumPins-1:0] = rise_en_q;
      REG_FALL_EN: rd_word[NumPins-1:0] = fall_en_q;
      REG_STATUS:  rd_word[NumPins-1:0] = status_q;
      REG_IRQ_EN:  rd_word[NumPins-1:0] = irq_en_q;
      default:     ;
    endcase

    rdata_d = (reg_req_i && !reg_we_i && mapped) ? rd_word : '0;
    error_d = reg_req_i & ~mapped;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= reg_req_i;
      error_q   <= error_d;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;
  assign reg_error_o  = error_q;
  assign pad_in_o     = dout_q;
  assign pad_oen_o    = ~dir_q;
  assign irq_o        = |(status_q & irq_en_q);

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Purpose: directed bench for pad_gpio_ctrl; register responses checked by a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_pad_gpio_ctrl;
  import pad_gpio_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_req_i;
  logic        reg_we_i;
  reg_addr_t   reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;
  logic        reg_error_o;
  logic [7:0]  pad_in_o;
  logic [7:0]  pad_oen_o;
  logic [7:0]  pad_out_i;
  logic        irq_o;

  logic        loop_en;
  logic [7:0]  ext;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign pad_out_i = loop_en ? pad_in_o : ext;

  always #5 clk_i = ~clk_i;

  pad_gpio_ctrl #(
    .NumPins(8), .DebounceCycles(4), .SyncStages(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_rvalid_o(reg_rvalid_o),
    .reg_error_o (reg_error_o),
    .pad_in_o    (pad_in_o),
    .pad_oen_o   (pad_oen_o),
    .pad_out_i   (pad_out_i),
    .irq_o       (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected response per rvalid cycle.
  always @(negedge clk_i) begin
    if (reg_rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: rvalid with empty queue, rdata %h at %0t", reg_rdata_o, $time);
      end else begin
        rsp_t r;
        r = exp_q.pop_front();
        check("sb_rdata", reg_rdata_o, r.rdata);
        check("sb_error", {31'b0, reg_error_o}, {31'b0, r.err});
      end
    end
  end

  task automatic bus(input logic we, input reg_addr_t addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    rsp_t r;
    r.rdata = exp_rd;
    r.err   = exp_err;
    exp_q.push_back(r);
    reg_req_i   = 1'b1;
    reg_we_i    = we;
    reg_addr_i  = addr;
    reg_wdata_i = wd;
    @(posedge clk_i); #1;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_wdata_i = '0;
    check("rvalid_lat", {31'b0, reg_rvalid_o}, 32'd1);
  endtask

  task automatic wr(input reg_addr_t addr, input logic [31:0] wd);
    bus(1'b1, addr, wd, 32'h0, 1'b0);
  endtask

  task automatic rd(input reg_addr_t addr, input logic [31:0] exp_rd);
    bus(1'b0, addr, 32'h0, exp_rd, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; reg_req_i = 1'b0; reg_we_i = 1'b0;
    reg_addr_i = '0; reg_wdata_i = '0;
    loop_en = 1'b1; ext = '0;
    idle(2);
    rst_i = 1'b0;

    // Reset state
    check("rst_oen", {24'b0, pad_oen_o}, 32'hFF);
    check("rst_in", {24'b0, pad_in_o}, 32'h00);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_rvalid", {31'b0, reg_rvalid_o}, 32'd0);
    rd(REG_DOUT, 0); rd(REG_DIR, 0); rd(REG_DIN, 0); rd(REG_RISE_EN, 0);
    rd(REG_FALL_EN, 0); rd(REG_STATUS, 0); rd(REG_IRQ_EN, 0);

    // Outputs and loopback
    wr(REG_DIR, 32'h0F);
    wr(REG_DOUT, 32'hFFFF_FFA5);
    check("oen_dir", {24'b0, pad_oen_o}, 32'hF0);
    check("pad_in", {24'b0, pad_in_o}, 32'hA5);
    idle(8);
    rd(REG_DIN, 32'hA5);
    rd(REG_DIR, 32'h0F);

    // Switch to external drive, let inputs settle low
    loop_en = 1'b0; ext = 8'h00;
    idle(8);
    rd(REG_DIN, 32'h00);
    rd(REG_STATUS, 32'h00);
    wr(REG_RISE_EN, 32'h01);
    wr(REG_IRQ_EN, 32'h01);

    // Rising edge on pin 0: filt/STATUS at edge k+5, irq after it
    ext = 8'h01;
    idle(5);
    check("irq_before_k5", {31'b0, irq_o}, 32'd0);
    idle(1);
    check("irq_at_k5", {31'b0, irq_o}, 32'd1);
    rd(REG_DIN, 32'h01);
    rd(REG_STATUS, 32'h01);
    wr(REG_STATUS, 32'h01);
    check("irq_cleared", {31'b0, irq_o}, 32'd0);
    rd(REG_STATUS, 32'h00);

    // Glitch rejection on pin 1
    wr(REG_RISE_EN, 32'hFF);
    wr(REG_FALL_EN, 32'hFF);
    ext = 8'h03;
    idle(3);
    ext = 8'h01;
    idle(8);
    rd(REG_DIN, 32'h01);
    rd(REG_STATUS, 32'h00);
    ext = 8'h03;
    idle(4);
    ext = 8'h01;
    idle(12);
    rd(REG_STATUS, 32'h02);
    rd(REG_DIN, 32'h01);
    check("irq_masked", {31'b0, irq_o}, 32'd0);
    wr(REG_STATUS, 32'hFF);

    // Clear and set on the same edge: set wins
    wr(REG_FALL_EN, 32'h00);
    ext = 8'h00;
    idle(8);
    wr(REG_STATUS, 32'hFF);
    rd(REG_STATUS, 32'h00);
    ext = 8'h01;
    idle(5);
    wr(REG_STATUS, 32'h01);
    rd(REG_STATUS, 32'h01);
    check("irq_set_wins", {31'b0, irq_o}, 32'd1);

    // Address errors
    bus(1'b0, 5'h1C, 32'h0, 32'h0, 1'b1);
    bus(1'b0, 5'h06, 32'h0, 32'h0, 1'b1);
    bus(1'b1, 5'h01, 32'hFF, 32'h0, 1'b1);
    rd(REG_DOUT, 32'hA5);

    // Reset mid-debounce
    ext = 8'h05;
    idle(3);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check("rst2_oen", {24'b0, pad_oen_o}, 32'hFF);
    check("rst2_in", {24'b0, pad_in_o}, 32'h00);
    check("rst2_irq", {31'b0, irq_o}, 32'd0);
    check("rst2_rvalid", {31'b0, reg_rvalid_o}, 32'd0);
    rd(REG_DIN, 32'h00);
    rd(REG_STATUS, 32'h00);
    rd(REG_RISE_EN, 32'h00);
    idle(8);
    rd(REG_DIN, 32'h05);

    idle(2);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
